// File: rtl/fechadura_pkg.sv
// fechadura_pkg: types and constants shared by the keypad decoder, the
// setup stage and the operational lock logic.
//   senhaPac_t  - 20-digit code buffer, digits[0] is the newest entry
//   KEY_*       - special 4-bit key codes
//   kbd_state_t - keypad scan FSM states
//   key_code()  - row/column to 4-bit code map
//   col_index() - index of the single low column in an active-low pattern
package fechadura_pkg;

    localparam int NUM_DIGITS = 20;

    localparam logic [3:0] KEY_STAR  = 4'hA;
    localparam logic [3:0] KEY_HASH  = 4'hB;
    localparam logic [3:0] KEY_EMPTY = 4'hF;

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] digits;
    } senhaPac_t;

    localparam senhaPac_t SENHA_EMPTY = senhaPac_t'({(NUM_DIGITS*4){1'b1}});

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        WAIT_REL  = 2'd2,
        DEB_REL   = 2'd3
    } kbd_state_t;

    // Keypad layout:
    //   r0: 1 2 3 A
    //   r1: 4 5 6 B
    //   r2: 7 8 9 C
    //   r3: * 0 # D
    // Column 3 holds the letter keys; their code value is never used.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = KEY_EMPTY;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_EMPTY;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] cols_n);
        logic [1:0] idx;
        idx = 2'd0;
        case (cols_n)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/teclado_debounce.sv
// teclado_debounce: stable-level counter.
//   clk, rst - clock, synchronous active-high reset
//   level    - condition being debounced (1 = condition currently holds)
//   restart  - clears the count; the counter only runs while this is low
//   stable   - one-cycle pulse on the DEBOUNCE_CYCLES-th consecutive cycle
//              with level high and restart low
module teclado_debounce #(
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic restart,
    output logic stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    assign stable = level && !restart && (cnt_q == LAST);

    // Count restarts after each stable pulse so the press and release phases
    // can share one counter.
    always_ff @(posedge clk) begin
        if (rst || restart || !level || stable) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/decodificador_teclado.sv
// decodificador_teclado: 4x4 keypad scanner and digit buffer.
//   clk, rst      - clock, synchronous active-high reset
//   col_matrix    - keypad columns, active-low
//   lin_matrix    - keypad rows, active-low, one row low at a time
//   digitos_value - 20-digit buffer, digits[0] newest
//   digitos_valid - one-cycle pulse, same edge as the buffer shift
//
// digitos_valid handshake: no back-pressure. A consumer samples
// digitos_value on any cycle where digitos_valid is high; the value is
// guaranteed for that cycle only (a terminator clears it on the next one).
module decodificador_teclado
    import fechadura_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic [3:0] col_matrix,
    output logic [3:0] lin_matrix,
    output senhaPac_t digitos_value,
    output logic      digitos_valid
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] IDLE_MAX  = TW'(TIMEOUT_CYCLES);

    kbd_state_t    state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    col_q;
    logic [1:0]    col_idx_q;
    logic [SW-1:0] scan_cnt_q;
    logic [TW-1:0] idle_cnt_q;
    senhaPac_t     digits_q;
    logic          valid_q;

    logic       single_low;
    logic       latch;
    logic       accept;
    logic       deb_level;
    logic       deb_restart;
    logic       deb_stable;
    logic [3:0] code;
    logic       code_ok;
    logic       term_seen;

    assign single_low = ($countones(~col_matrix) == 1);
    assign code       = key_code(row_q, col_idx_q);
    assign code_ok    = accept && (col_idx_q != 2'd3);
    assign term_seen  = valid_q && ((digits_q.digits[0] == KEY_STAR) ||
                                    (digits_q.digits[0] == KEY_HASH));

    teclado_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .level  (deb_level),
        .restart(deb_restart),
        .stable (deb_stable)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        latch       = 1'b0;
        accept      = 1'b0;
        deb_level   = 1'b0;
        deb_restart = 1'b1;
        case (state_q)
            SCAN: begin
                // Multi-column patterns are ghosting or chords: keep rotating.
                if (single_low) begin
                    latch   = 1'b1;
                    state_d = DEB_PRESS;
                end else if (scan_cnt_q == SCAN_LAST) begin
                    row_d = row_q + 2'd1;
                end
            end
            DEB_PRESS: begin
                deb_restart = 1'b0;
                deb_level   = (col_matrix == col_q);
                if (deb_stable) begin
                    accept  = 1'b1;
                    state_d = WAIT_REL;
                end else if (!deb_level) begin
                    state_d = SCAN;
                end
            end
            WAIT_REL: begin
                if (col_matrix == 4'hF) begin
                    state_d = DEB_REL;
                end
            end
            DEB_REL: begin
                deb_restart = 1'b0;
                deb_level   = (col_matrix == 4'hF);
                if (deb_stable) begin
                    state_d = SCAN;
                end else if (!deb_level) begin
                    state_d = WAIT_REL;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            row_q      <= 2'd0;
            col_q      <= 4'hF;
            col_idx_q  <= 2'd0;
            scan_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            if (latch) begin
                col_q     <= col_matrix;
                col_idx_q <= col_index(col_matrix);
            end
            // The divider only runs while scanning, so a return to SCAN
            // gives the held row a full SCAN_DIV period.
            if (state_q == SCAN && !latch && scan_cnt_q != SCAN_LAST) begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end else begin
                scan_cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q   <= SENHA_EMPTY;
            valid_q    <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            valid_q <= code_ok;
            if (code_ok) begin
                idle_cnt_q <= '0;
            end else if (idle_cnt_q != IDLE_MAX) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
            if (code_ok) begin
                digits_q.digits <= {digits_q.digits[NUM_DIGITS-2:0], code};
            end else if (term_seen) begin
                digits_q <= SENHA_EMPTY;
            end else if (idle_cnt_q == IDLE_MAX && digits_q != SENHA_EMPTY) begin
                digits_q <= SENHA_EMPTY;
            end
        end
    end

    assign lin_matrix    = ~(4'b0001 << row_q);
    assign digitos_value = digits_q;
    assign digitos_valid = valid_q;

endmodule
